// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared FSM encoding and default address map for the I/O bus decoder
package io_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [31:0] VGA_BASE  = 32'h1081_0000;
  localparam logic [31:0] ENET_BASE = 32'h1081_0004;
  localparam int          DEF_SLV   = 0;

endpackage

// File: rtl/io_bus_decoder_if.sv
// rtl/io_bus_decoder_if.sv - CPU-side and slave-side bus signals of the I/O bus decoder
interface io_bus_decoder_if #(
  parameter int N_SLV  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                    cpu_cs;
  logic                    cpu_we;
  logic                    cpu_re;
  logic [ADDR_W-1:0]       cpu_addr;
  logic [DATA_W-1:0]       cpu_wdata;
  logic [DATA_W-1:0]       cpu_rdata;
  logic                    cpu_ready;
  logic                    cpu_err;
  logic [N_SLV-1:0]        slv_cs;
  logic                    slv_we;
  logic                    slv_re;
  logic [ADDR_W-1:0]       slv_addr;
  logic [DATA_W-1:0]       slv_wdata;
  logic [N_SLV*DATA_W-1:0] slv_rdata;
  logic [N_SLV-1:0]        slv_ack;

  // master: the CPU plus the slave array around the decoder
  modport master (
    output cpu_cs, cpu_we, cpu_re, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_err,
    input  slv_cs, slv_we, slv_re, slv_addr, slv_wdata,
    output slv_rdata, slv_ack
  );

  // slave: the decoder itself
  modport slave (
    input  cpu_cs, cpu_we, cpu_re, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_err,
    output slv_cs, slv_we, slv_re, slv_addr, slv_wdata,
    input  slv_rdata, slv_ack
  );
endinterface

// File: rtl/io_addr_match.sv
// rtl/io_addr_match.sv - combinational priority window match; no hit falls through to slave 0
module io_addr_match
  import io_bus_pkg::*;
#(
  parameter int N_SLV  = 3,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = $clog2(N_SLV)
) (
  input  logic [ADDR_W-1:0]       addr,
  input  logic [N_SLV*ADDR_W-1:0] base,
  input  logic [N_SLV*ADDR_W-1:0] mask,
  output logic [N_SLV-1:0]        hit,
  output logic [IDX_W-1:0]        idx
);

  logic found;
  // slice 0 is the default target and has no window of its own
  logic unused_slice0;
  assign unused_slice0 = ^{base[ADDR_W-1:0], mask[ADDR_W-1:0]};

  always_comb begin
    found = 1'b0;
    idx   = IDX_W'(DEF_SLV);
    for (int i = 1; i < N_SLV; i++) begin
      if (!found && ((addr & mask[i*ADDR_W +: ADDR_W]) == base[i*ADDR_W +: ADDR_W])) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
    hit      = '0;
    hit[idx] = 1'b1;
  end

endmodule

// File: rtl/io_bus_decoder.sv
// rtl/io_bus_decoder.sv - registered handshaked I/O bus decoder with ack timeout and error count
module io_bus_decoder
  import io_bus_pkg::*;
#(
  parameter int                    N_SLV   = 3,
  parameter int                    ADDR_W  = 32,
  parameter int                    DATA_W  = 32,
  parameter logic [N_SLV*ADDR_W-1:0] BASE  = {ENET_BASE, VGA_BASE, 32'h0},
  parameter logic [N_SLV*ADDR_W-1:0] MASK  = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0},
  parameter int                    TIMEOUT = 16,
  parameter int                    ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  io_bus_decoder_if.slave  bus,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int IDX_W = $clog2(N_SLV);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [N_SLV-1:0]  hit;
  logic [IDX_W-1:0]  hit_idx;

  state_t            state;
  logic [IDX_W-1:0]  sel_q;
  logic [TMR_W-1:0]  timer;
  logic [N_SLV-1:0]  cs_q;
  logic              we_q;
  logic              re_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              err_q;
  logic [ERR_W-1:0]  cnt_q;
  logic              req;

  io_addr_match #(
    .N_SLV  (N_SLV),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_match (
    .addr (bus.cpu_addr),
    .base (BASE),
    .mask (MASK),
    .hit  (hit),
    .idx  (hit_idx)
  );

  assign req = bus.cpu_cs & (bus.cpu_we | bus.cpu_re);

  // slv_cs is a flop on the async reset, so a mid-access reset drops it at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sel_q   <= '0;
      timer   <= '0;
      cs_q    <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b0;
          if (req) begin
            state   <= ST_ACCESS;
            sel_q   <= hit_idx;
            cs_q    <= hit;
            we_q    <= bus.cpu_we;
            re_q    <= bus.cpu_re & ~bus.cpu_we;
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
            timer   <= '0;
          end
        end
        ST_ACCESS: begin
          if (bus.slv_ack[sel_q]) begin
            rdata_q <= we_q ? '0 : bus.slv_rdata[sel_q*DATA_W +: DATA_W];
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            cs_q    <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            state   <= ST_DONE;
          end else if ((TIMEOUT != 0) && (timer == TMR_LAST)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            ready_q <= 1'b1;
            cs_q    <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            state   <= ST_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DONE: begin
          ready_q <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_ready = ready_q;
  assign bus.cpu_err   = err_q;
  assign bus.slv_cs    = cs_q;
  assign bus.slv_we    = we_q;
  assign bus.slv_re    = re_q;
  assign bus.slv_addr  = addr_q;
  assign bus.slv_wdata = wdata_q;
  assign err_cnt       = cnt_q;

endmodule

// File: tb/tb_io_bus_decoder.sv
// tb/tb_io_bus_decoder.sv - randomized self-checking bench for io_bus_decoder
module tb_io_bus_decoder;
  import io_bus_pkg::*;

  localparam int TIMEOUT = 16;
  // slave 2 window covers 0x1081_0000..0x1081_000F and so overlaps slave 1
  localparam logic [95:0] TB_BASE = {32'h1081_0000, VGA_BASE, 32'h0};
  localparam logic [95:0] TB_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h0};

  logic       clk;
  logic       rst_n;
  logic [7:0] err_cnt;

  io_bus_decoder_if #(.N_SLV(3), .ADDR_W(32), .DATA_W(32)) bus ();

  io_bus_decoder #(
    .N_SLV(3), .ADDR_W(32), .DATA_W(32),
    .BASE(TB_BASE), .MASK(TB_MASK),
    .TIMEOUT(TIMEOUT), .ERR_W(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [2:0]  exp_cs    = '0;
  logic        exp_ready = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err   = 1'b0;
  logic [7:0]  exp_cnt   = '0;
  logic        chk_slv   = 1'b0;
  logic        exp_we    = 1'b0;
  logic        exp_re    = 1'b0;
  logic [31:0] exp_addr  = '0;
  logic [31:0] exp_wdata = '0;

  int          req_cyc      = 0;
  int          cs_run       = 0;
  int          last_cs_run  = 0;
  int          last_lat     = 0;
  int          ready_pulses = 0;
  logic [2:0]  last_cs_val  = '0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int ref_sel(input logic [31:0] a);
    for (int i = 1; i < 3; i++)
      if ((a & TB_MASK[i*32 +: 32]) == TB_BASE[i*32 +: 32]) return i;
    return 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    chk("slv_cs", 64'(bus.slv_cs), 64'(exp_cs));
    chk("cpu_ready", 64'(bus.cpu_ready), 64'(exp_ready));
    chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(exp_rdata));
    chk("cpu_err", 64'(bus.cpu_err), 64'(exp_err));
    chk("err_cnt", 64'(err_cnt), 64'(exp_cnt));
    if (chk_slv) begin
      chk("slv_we", 64'(bus.slv_we), 64'(exp_we));
      chk("slv_re", 64'(bus.slv_re), 64'(exp_re));
      chk("slv_addr", 64'(bus.slv_addr), 64'(exp_addr));
      chk("slv_wdata", 64'(bus.slv_wdata), 64'(exp_wdata));
    end
    if (bus.slv_cs != 3'b000) begin
      cs_run++;
      last_cs_val = bus.slv_cs;
    end
    if (bus.cpu_ready) begin
      last_cs_run = cs_run;
      cs_run      = 0;
      last_lat    = cyc - req_cyc + 1;
      ready_pulses++;
    end
  end

  // one transaction: lat = ACCESS cycle in which the selected slave acks; 0 or >TIMEOUT = never
  task automatic txn(input logic we, input logic re, input logic [31:0] addr,
                     input logic [31:0] wdata, input int lat, input logic [31:0] rd,
                     input logic [2:0] noise);
    int sel;
    int n;
    bit tout;
    sel  = ref_sel(addr);
    tout = (lat <= 0) || (lat > TIMEOUT);
    n    = tout ? TIMEOUT : lat;
    bus.cpu_cs = 1'b1; bus.cpu_we = we; bus.cpu_re = re;
    bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.slv_ack = '0;
    exp_cs = '0; exp_ready = 1'b0; chk_slv = 1'b0; req_cyc = cyc;
    @(posedge clk); #1;
    for (int j = 1; j <= n; j++) begin
      exp_cs = 3'b001 << sel; chk_slv = 1'b1;
      exp_we = we; exp_re = re & ~we; exp_addr = addr; exp_wdata = wdata;
      bus.cpu_we = 1'($urandom); bus.cpu_re = 1'($urandom);
      bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom;
      for (int k = 0; k < 3; k++) bus.slv_rdata[k*32 +: 32] = (k == sel) ? rd : $urandom;
      bus.slv_ack = noise & ~(3'b001 << sel);
      if (!tout && j == n) bus.slv_ack[sel] = 1'b1;
      @(posedge clk); #1;
    end
    bus.slv_ack = '0; exp_cs = '0; chk_slv = 1'b0; exp_ready = 1'b1;
    if (tout) begin
      exp_err = 1'b1; exp_rdata = '0;
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    end else begin
      exp_err = 1'b0; exp_rdata = we ? 32'h0 : rd;
    end
    @(posedge clk); #1;
    exp_ready = 1'b0;
    bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;
  endtask

  task automatic idle(input int n, input logic junk_cs);
    for (int j = 0; j < n; j++) begin
      bus.cpu_cs = junk_cs; bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;
      bus.cpu_addr = $urandom; bus.slv_ack = 3'($urandom);
      exp_cs = '0; exp_ready = 1'b0; chk_slv = 1'b0;
      @(posedge clk); #1;
    end
    bus.slv_ack = '0; bus.cpu_cs = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    int          p0;
    rst_n = 1'b1;
    bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.slv_rdata = '0; bus.slv_ack = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_cs", 64'(bus.slv_cs), 64'h0);
    chk("reset_ready", 64'(bus.cpu_ready), 64'h0);
    chk("reset_err_cnt", 64'(err_cnt), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    txn(1'b0, 1'b1, 32'h1081_0000, 32'h0, 1, 32'hA5A5_0001, 3'b000);
    chk("read_lat", 64'(last_lat), 64'd3);
    chk("read_cs_cycles", 64'(last_cs_run), 64'd1);
    chk("read_cs_val", 64'(last_cs_val), 64'h2);
    chk("read_rdata", 64'(bus.cpu_rdata), 64'hA5A5_0001);
    chk("read_err", 64'(bus.cpu_err), 64'h0);

    idle(2, 1'b0);
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 4, 32'hDEAD_BEEF, 3'b000);
    chk("write_lat", 64'(last_lat), 64'd6);
    chk("write_cs_cycles", 64'(last_cs_run), 64'd4);
    chk("write_cs_val", 64'(last_cs_val), 64'h1);
    chk("write_rdata", 64'(bus.cpu_rdata), 64'h0);

    txn(1'b0, 1'b1, ENET_BASE, 32'h0, 0, 32'h0, 3'b000);
    chk("tout_lat", 64'(last_lat), 64'd18);
    chk("tout_cs_cycles", 64'(last_cs_run), 64'd16);
    chk("tout_cs_val", 64'(last_cs_val), 64'h4);
    chk("tout_err", 64'(bus.cpu_err), 64'h1);
    chk("tout_err_cnt", 64'(err_cnt), 64'd1);

    txn(1'b0, 1'b1, 32'h1081_0000, 32'h0, 0, 32'h0, 3'b100);
    chk("overlap_cs_val", 64'(last_cs_val), 64'h2);
    chk("wrong_ack_err", 64'(bus.cpu_err), 64'h1);
    chk("wrong_ack_err_cnt", 64'(err_cnt), 64'd2);

    txn(1'b0, 1'b1, 32'h1081_000F, 32'h0, TIMEOUT, 32'h0BAD_F00D, 3'b011);
    chk("last_cycle_ack_err", 64'(bus.cpu_err), 64'h0);
    chk("last_cycle_ack_rdata", 64'(bus.cpu_rdata), 64'h0BAD_F00D);

    idle(3, 1'b1);
    p0 = ready_pulses;
    txn(1'b1, 1'b1, 32'h1081_0010, 32'hCAFE_0001, 2, 32'h1111_2222, 3'b000);
    txn(1'b0, 1'b1, VGA_BASE, 32'h0, 1, 32'h3333_4444, 3'b111);
    chk("b2b_pulses", 64'(ready_pulses - p0), 64'd2);
    chk("b2b_rdata", 64'(bus.cpu_rdata), 64'h3333_4444);

    // reset in the middle of an access
    bus.cpu_cs = 1'b1; bus.cpu_we = 1'b0; bus.cpu_re = 1'b1;
    bus.cpu_addr = VGA_BASE; bus.cpu_wdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    exp_cs = 3'b010; chk_slv = 1'b1; exp_we = 1'b0; exp_re = 1'b1;
    exp_addr = VGA_BASE; exp_wdata = 32'h5555_AAAA; bus.cpu_cs = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    exp_cs = '0; chk_slv = 1'b0; exp_rdata = '0; exp_err = 1'b0; exp_cnt = '0;
    p0 = ready_pulses;
    #1;
    chk("rst_async_cs", 64'(bus.slv_cs), 64'h0);
    cs_run = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rst_no_ready", 64'(ready_pulses - p0), 64'd0);
    txn(1'b0, 1'b1, VGA_BASE, 32'h0, 1, 32'h7777_0007, 3'b000);
    chk("post_rst_lat", 64'(last_lat), 64'd3);
    chk("post_rst_rdata", 64'(bus.cpu_rdata), 64'h7777_0007);

    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 4))
        0: a = VGA_BASE;
        1: a = ENET_BASE;
        2: a = 32'h1081_000C;
        3: a = 32'h1081_0010;
        default: a = $urandom;
      endcase
      kind = $urandom_range(0, 2);
      txn(kind != 0, kind != 1, a, $urandom, $urandom_range(0, TIMEOUT + 1), $urandom,
          ($urandom_range(0, 1) != 0) ? 3'($urandom) : 3'b000);
      if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 3), 1'($urandom));
    end

    for (int t = 0; t < 300; t++)
      txn(1'b0, 1'b1, ENET_BASE, 32'h0, 0, 32'h0, 3'($urandom));
    chk("err_cnt_saturated", 64'(err_cnt), 64'd255);

    idle(2, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_bus_decoder.md
Name: io_bus_decoder

Overview:
- Parametrised successor to the CPU54 combinational memory-mapped I/O chip-select decode. This block is a registered, handshaked bus decoder.
- It sits between the CPU data-memory port and N slaves. Slave 0 is the default target, normally dmem.
- It decodes programmable address windows and drives exactly one one-hot slave chip-select.
- It waits for a per-slave ack and returns read data to the CPU with a ready strobe.
- It flags a bus error if the selected slave does not ack within a timeout, and keeps a saturating error count.

Parameters:
- N_SLV, 3, number of slaves; index 0 is the default (dmem) target; minimum 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- BASE, {32'h10810004,32'h10810000,32'h0}, packed N_SLV*ADDR_W window bases; slice i belongs to slave i; slice 0 is ignored.
- MASK, {32'hFFFFFFFF,32'hFFFFFFFF,32'h0}, packed N_SLV*ADDR_W compare masks; slice 0 is ignored.
- TIMEOUT, 16, number of ACCESS cycles without an ack before an error is raised; 0 disables the timeout.
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- cpu_cs  in  1  CPU data-port request.
- cpu_we  in  1  write request.
- cpu_re  in  1  read request.
- cpu_addr  in  ADDR_W  request address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion strobe.
- cpu_err  out  1  error flag; valid with cpu_ready.
- slv_cs  out  N_SLV  one-hot slave chip-select.
- slv_we  out  1  registered write enable.
- slv_re  out  1  registered read enable.
- slv_addr  out  ADDR_W  registered address.
- slv_wdata  out  DATA_W  registered write data.
- slv_rdata  in  N_SLV*DATA_W  packed slave read data; slice i belongs to slave i.
- slv_ack  in  N_SLV  per-slave completion acknowledge.
- err_cnt  out  ERR_W  saturating timeout-error count.

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - rst_n is asynchronous and active low.
  - While rst_n=0, all outputs are 0, the FSM is in IDLE, and the timer and err_cnt are 0.
  - Reset mid-transaction drops slv_cs immediately, without waiting for a clock edge. No ready strobe is issued for the aborted access.
- Address match:
  - Slave i (i>=1) hits when (cpu_addr & MASK[i]) == BASE[i].
  - If several slaves hit, the lowest hitting index i>=1 wins.
  - If no slave hits, slave 0 is selected.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - cpu_ready=0 and slv_cs=0.
  - If cpu_cs & (cpu_we | cpu_re): register addr, wdata, we, re and the selected index; clear the timer; go to ACCESS.
  - cpu_cs with both we=0 and re=0 is ignored.
  - If we and re are both 1, the request is treated as a write (slv_re=0).
- ACCESS:
  - slv_cs[sel]=1, and slv_we/slv_re/slv_addr/slv_wdata are held stable.
  - If slv_ack[sel]=1: capture slv_rdata slice sel (captured data is 0 for writes), set err=0, go to DONE.
  - Else, if TIMEOUT!=0 and the timer equals TIMEOUT-1: set err=1, rdata=0, increment err_cnt (saturating at all-ones), go to DONE.
  - Otherwise the timer increments.
  - Acks from non-selected slaves are ignored.
  - An ack in the first ACCESS cycle is valid.
- DONE:
  - cpu_ready=1 for exactly one cycle, with cpu_rdata and cpu_err valid.
  - slv_cs=0; return to IDLE.
  - cpu_rdata and cpu_err hold their values until the next DONE.
- Latency:
  - Minimum is 3 cycles from the request edge to cpu_ready (IDLE sample, 1 ACCESS cycle, DONE).
  - A timed-out access takes TIMEOUT+2 cycles.
- Back-to-back: cpu_cs still high in the IDLE cycle after DONE starts a new transaction. The CPU deasserts cs on ready if it has no further request.
- CPU inputs are sampled only in IDLE; changes during ACCESS or DONE have no effect.

Decomposition:
- Shared package io_bus_pkg holds:
  - FSM state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2).
  - Default map constants VGA_BASE=32'h10810000 and ENET_BASE=32'h10810004.
  - DEF_SLV=0.
- Sub-module io_addr_match: combinational priority window match (addr, BASE, MASK -> one-hot hit and index), instantiated once. The FSM, timer, counter and data capture live in the top.

Test Plan:
- Default-map read: cpu_re with addr=32'h10810000, slave 1 acks in the first ACCESS cycle with rdata=32'hA5A5_0001 -> slv_cs=3'b010 for 1 cycle; cpu_ready 3 cycles after the request; cpu_rdata=32'hA5A5_0001; cpu_err=0.
- Default fallthrough write: cpu_we, addr=32'h0000_0040, wdata=32'h1234_5678, slave 0 acks after 4 cycles -> slv_cs=3'b001 held 4 cycles; slv_wdata=32'h1234_5678; cpu_ready at cycle 6; cpu_rdata=0.
- Timeout: TIMEOUT=16, read addr=32'h10810004, no ack -> slv_cs=3'b100 for 16 cycles; cpu_ready with cpu_err=1 and cpu_rdata=0; err_cnt increments 0 to 1. Repeat 300 times with ERR_W=8 -> err_cnt saturates at 255.
- Wrong-slave ack and overlap: configure overlapping windows 1 and 2; a hit in both selects slave 1. An ack on slv_ack[2] only -> ignored and the access times out.
- Back-to-back and control sampling:
  - cpu_cs held high for 2 requests -> two transactions, each with its own one-cycle ready pulse.
  - cpu_cs=1 with we=re=0 -> no slv_cs.
  - cpu_addr changed during ACCESS -> slv_addr unchanged.
- Reset mid-ACCESS: assert rst_n=0 between clock edges during ACCESS -> slv_cs drops to 0 asynchronously; no cpu_ready; after release the next request completes normally.
